// File: rtl/lm32_rf_pkg.sv
// Shared types for the LM32 2R1W register file: default geometry,
// entry/address typedefs and the clear-sequencer state encoding.
package lm32_rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/lm32_rf_rdport.sv
// One registered read port: R0 forcing, optional write-to-read bypass
// and the output register that holds its value while the pipeline stalls.
module lm32_rf_rdport
    import lm32_rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] sel_data;

    // Pick the value to capture: hardwired zero beats bypass, bypass beats the array.
    always_comb begin
        sel_data = mem_rdata;
        if (BYPASS && we && (waddr == raddr)) begin
            sel_data = wdata;
        end
        if (ZERO_R0 && (raddr == '0)) begin
            sel_data = '0;
        end
    end

    // Output register; en low (stall or clear in progress) keeps the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= sel_data;
        end
    end

endmodule

// File: rtl/lm32_regfile_2r1w.sv
// Parametrised 2-read/1-write register file with registered reads,
// same-cycle bypass and a clear sequencer that fills every entry after reset.
module lm32_regfile_2r1w
    import lm32_rf_pkg::*;
#(
    parameter int              DATA_W    = RF_DATA_W,
    parameter int              ADDR_W    = RF_ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit              BYPASS    = 1'b1,
    parameter bit              ZERO_R0   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              init_busy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              busy_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              port_en;

    // Sequencer state, clear counter and busy flag; busy is its own flop so it
    // leaves the block without any decode logic in front of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            init_busy <= busy_next;
        end
    end

    // Next-state logic: walk every address once, then hand over to the core.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_next  = init_busy;
        case (state)
            INIT: begin
                cnt_next = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) begin
                    state_next = READY;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                end
            end
            READY: begin
                busy_next = 1'b0;
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
                busy_next  = 1'b1;
            end
        endcase
    end

    // Single array write port: the clear sequencer owns it during INIT,
    // writeback owns it afterwards (R0 writes dropped when R0 is hardwired).
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = RESET_VAL;
        end else if (we && !(ZERO_R0 && (waddr == '0))) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; deliberately not reset so it stays a distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign port_en = rd_en && (state == READY);

    lm32_rf_rdport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .en        (port_en),
        .raddr     (raddr_a),
        .mem_rdata (mem[raddr_a]),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .rdata     (rdata_a)
    );

    lm32_rf_rdport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .en        (port_en),
        .raddr     (raddr_b),
        .mem_rdata (mem[raddr_b]),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .rdata     (rdata_b)
    );

endmodule

// File: doc/lm32_regfile_2r1w.md
# lm32_regfile_2r1w

Parametrised 2-read/1-write register file for the LM32 pipeline. It is the successor to the fixed 32x32 distributed-RAM file and adds four things: configurable width and depth, registered reads with a stall enable, same-cycle write-to-read bypass, and a hardware clear sequencer that initialises every entry after reset. It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
Parameters:
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W, derived, not overridable
- RESET_VAL, 0, DATA_W-bit value written to every entry by the clear sequencer
- BYPASS, 1, 1 = same-cycle write forwarded to matching read; 0 = read returns old contents
- ZERO_R0, 0, 1 = entry 0 hardwired to zero (writes dropped, reads return 0)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- rd_en  in  1  read-register enable; 0 = hold outputs (pipeline stall)
- raddr_a  in  ADDR_W  read port A address
- raddr_b  in  ADDR_W  read port B address
- rdata_a  out  DATA_W  registered read data A
- rdata_b  out  DATA_W  registered read data B
- init_busy  out  1  clear sequencer active; core must hold in stall

## Operation
- States: INIT, READY. rst forces INIT, init counter = 0, init_busy = 1, rdata_a/b = 0.
- INIT: each cycle writes RESET_VAL to mem[cnt], cnt++. External we and rd_en are ignored, and rdata_a/b hold 0. After the write to DEPTH-1: state becomes READY, init_busy = 0, cnt wraps to 0.
- READY, write: when we = 1, mem[waddr] <= wdata on the clk edge. When ZERO_R0 = 1 and waddr = 0, the write is dropped.
- READY, read: when rd_en = 1, rdata_x <= f(raddr_x) on the clk edge. f is chosen in this order:
  - 0, if ZERO_R0 = 1 and raddr_x = 0;
  - wdata, if BYPASS = 1, we = 1 and waddr = raddr_x;
  - mem[raddr_x] otherwise.
- rd_en = 0: rdata_a/b hold their values. Writes still occur.
- Ports A and B are independent and may use the same address; both then return identical data.
- rst asserted mid-INIT or mid-READY: returns to INIT at cnt = 0 and the full clear reruns. Memory contents are not guaranteed until init_busy falls.

## Timing
- Read latency 1 cycle: address at edge N gives data valid after edge N.
- Write then read of the same address in the next cycle returns the new data from the array. This holds regardless of BYPASS.
- Same-cycle write and read of the same address:
  - BYPASS = 1 returns the new data;
  - BYPASS = 0 returns the previous contents.
- Clear duration is exactly DEPTH cycles after rst deasserts: 32 cycles at ADDR_W = 5. init_busy falls on the edge that completes the DEPTH-th write. The first read accepted is on the following edge.
- No combinational path from inputs to outputs. init_busy is a flop output.

## Structure
- Shared package `lm32_rf_pkg`: the state enum (INIT/READY) and the `rf_addr_t` / `rf_data_t` typedefs parameterised via localparams.
- Single sub-module `lm32_rf_rdport`, instantiated twice. It holds the per-port bypass, R0 mux and output register.
- The storage array is one inferred memory. It has an asynchronous internal read and one write port, muxed between the clear sequencer and the external write. It must map to distributed RAM; do not reset the array itself.

## Test plan
- Reset and clear, default parameters: release rst, count cycles → init_busy high for exactly 32 cycles, then 0. Afterwards, reading all 32 addresses on A and B returns 0x00000000.
- Write then read: we = 1 with waddr = 7 and wdata = 0xDEADBEEF. Next cycle raddr_a = 7 and rd_en = 1 → rdata_a = 0xDEADBEEF after one edge.
- Bypass:
  - BYPASS = 1: we = 1, waddr = 3, wdata = 0x12345678, with raddr_b = 3 and rd_en = 1 in the same cycle → rdata_b = 0x12345678.
  - BYPASS = 0, same stimulus → rdata_b = the old value, 0.
- Stall: hold rd_en = 0 for 4 cycles while raddr_a changes and a write hits the held address → rdata_a is unchanged. Then rd_en = 1 → the new value appears after one edge.
- ZERO_R0 = 1: write 0xFFFFFFFF to address 0, then read address 0 on both ports → 0. A write to address 1 is unaffected.
- Reset mid-clear: assert rst at INIT cycle 10 for one cycle → init_busy stays 1 and the clear reruns a full 32 cycles. RESET_VAL = 0xA5A5A5A5 → every entry reads back 0xA5A5A5A5.
